pipe_ctrl: RTL and testbench

Pipeline control unit: the producer of the `StallBus` stall vector and the mispredict flush/redirect that the inter-stage registers (if_id, id_ex, ex_mem, mem_wb) and pc_reg consume. It arbitrates stall requests from fetch, decode, memory and the memory controller's ready line. It also sequences branch-mispredict recovery so a redirect raised during a stall is held until the pipeline can accept it. The unit sits beside the datapath, with one instance per core.

---
 rtl/pipe_ctrl.sv | 117 +++++++++++
 tb/tb_pipe_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline control: stall vector arbitration and mispredict flush/redirect sequencing.
// Optional performance counters are enabled by defining PIPE_PERF_CNT_EN.
module pipe_ctrl #(
  parameter int STALL_W = 6,
  parameter int ADDR_W  = 32
`ifdef PIPE_PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy_in,
  input  logic               stallreq_if,
  input  logic               stallreq_id,
  input  logic               stallreq_mem,
  input  logic               ex_jmp_wrong_i,
  input  logic [ADDR_W-1:0]  ex_jmp_target_i,
  output logic [STALL_W-1:0] stall,
  output logic               flush_o,
  output logic [ADDR_W-1:0]  redirect_pc_o,
  output logic               busy_o
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]   cnt_stall_o,
  output logic [CNT_W-1:0]   cnt_flush_o,
  output logic [CNT_W-1:0]   cnt_hold_o
`endif
);

  typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_e;

  localparam logic [STALL_W-1:0] STALL_ALL = '1;
  localparam logic [STALL_W-1:0] STALL_MEM = {{(STALL_W-5){1'b0}}, 5'b11111};
  localparam logic [STALL_W-1:0] STALL_ID  = {{(STALL_W-3){1'b0}}, 3'b111};
  localparam logic [STALL_W-1:0] STALL_IF  = {{(STALL_W-2){1'b0}}, 2'b11};

  state_e              state_q;
  logic [ADDR_W-1:0]   pend_q;

  logic                ex_stop;
  logic                flush_c;
  logic [STALL_W-1:0]  stall_c;
  logic [ADDR_W-1:0]   redirect_c;

  // ex is frozen exactly when rdy_in drops or mem stalls; computing it apart
  // from the full vector keeps flush -> id-suppression free of a comb loop.
  assign ex_stop = ~rdy_in | stallreq_mem;

  always_comb begin
    flush_c    = 1'b0;
    redirect_c = '0;
    stall_c    = '0;
    if (state_q == HOLD) begin
      flush_c = ~ex_stop;
      if (flush_c) redirect_c = pend_q;
    end else begin
      flush_c = ex_jmp_wrong_i & ~ex_stop;
      if (flush_c) redirect_c = ex_jmp_target_i;
    end
    if (!rdy_in)                       stall_c = STALL_ALL;
    else if (stallreq_mem)             stall_c = STALL_MEM;
    else if (stallreq_id && !flush_c)  stall_c = STALL_ID;
    else if (stallreq_if)              stall_c = STALL_IF;
    if (!rst) begin
      flush_c    = 1'b0;
      redirect_c = '0;
      stall_c    = '0;
    end
  end

  assign stall         = stall_c;
  assign flush_o       = flush_c;
  assign redirect_pc_o = redirect_c;
  assign busy_o        = rst & (state_q == HOLD);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= RUN;
      pend_q  <= '0;
    end else begin
      case (state_q)
        RUN: begin
          if (ex_jmp_wrong_i && ex_stop) begin
            state_q <= HOLD;
            pend_q  <= ex_jmp_target_i;
          end
        end
        HOLD: begin
          // ex still holds the same mispredicted instruction; its re-assertion is ignored.
          if (!ex_stop) state_q <= RUN;
        end
        default: state_q <= RUN;
      endcase
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] cnt_stall_q, cnt_flush_q, cnt_hold_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_stall_q <= '0;
      cnt_flush_q <= '0;
      cnt_hold_q  <= '0;
    end else begin
      if (|stall_c && cnt_stall_q != '1)            cnt_stall_q <= cnt_stall_q + 1'b1;
      if (flush_c && cnt_flush_q != '1)             cnt_flush_q <= cnt_flush_q + 1'b1;
      if (state_q == HOLD && cnt_hold_q != '1)      cnt_hold_q  <= cnt_hold_q + 1'b1;
    end
  end

  assign cnt_stall_o = cnt_stall_q;
  assign cnt_flush_o = cnt_flush_q;
  assign cnt_hold_o  = cnt_hold_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized and directed bench for pipe_ctrl against a queue-free behavioural model.
module tb_pipe_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rdy_in, sif, sid, smem, wrong;
  logic [31:0] tgt;
  logic [5:0]  stall;
  logic        flush_o, busy_o;
  logic [31:0] redirect_pc_o;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] cs, cf, ch;
  logic [1:0]  cs2, cf2, ch2;
`endif

  int checks = 0;
  int failures = 0;

  // model state: is a redirect waiting, and where to
  bit          m_pend;
  logic [31:0] m_addr;
  longint      m_cs, m_cf, m_ch;
  logic [5:0]  e_stall;
  logic        e_flush, e_busy;
  logic [31:0] e_pc;

  pipe_ctrl dut (
    .clk(clk), .rst(rst), .rdy_in(rdy_in), .stallreq_if(sif), .stallreq_id(sid),
    .stallreq_mem(smem), .ex_jmp_wrong_i(wrong), .ex_jmp_target_i(tgt),
    .stall(stall), .flush_o(flush_o), .redirect_pc_o(redirect_pc_o), .busy_o(busy_o)
`ifdef PIPE_PERF_CNT_EN
    , .cnt_stall_o(cs), .cnt_flush_o(cf), .cnt_hold_o(ch)
`endif
  );

`ifdef PIPE_PERF_CNT_EN
  logic [5:0]  stall2;
  logic        flush2, busy2;
  logic [31:0] pc2;
  pipe_ctrl #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .rdy_in(rdy_in), .stallreq_if(sif), .stallreq_id(sid),
    .stallreq_mem(smem), .ex_jmp_wrong_i(wrong), .ex_jmp_target_i(tgt),
    .stall(stall2), .flush_o(flush2), .redirect_pc_o(pc2), .busy_o(busy2),
    .cnt_stall_o(cs2), .cnt_flush_o(cf2), .cnt_hold_o(ch2)
  );
`endif

  function automatic void model_eval();
    bit ex_frozen;
    e_stall = 6'b000000; e_flush = 1'b0; e_pc = 32'h0; e_busy = 1'b0;
    if (rst) begin
      ex_frozen = !rdy_in || smem;
      e_busy  = m_pend;
      e_flush = !ex_frozen && (m_pend || wrong);
      if (e_flush) e_pc = m_pend ? m_addr : tgt;
      if (!rdy_in)               e_stall = 6'b111111;
      else if (smem)             e_stall = 6'b011111;
      else if (sid && !e_flush)  e_stall = 6'b000111;
      else if (sif)              e_stall = 6'b000011;
    end
  endfunction

  // inputs applied at posedge+1, outputs settled by posedge+5
  task automatic set_in(input logic r, input logic rdy, input logic i, input logic d,
                        input logic m, input logic w, input logic [31:0] t);
    rst = r; rdy_in = rdy; sif = i; sid = d; smem = m; wrong = w; tgt = t;
    #4;
    model_eval();
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      m_pend = 0; m_addr = 0; m_cs = 0; m_cf = 0; m_ch = 0;
    end else begin
      if (e_stall != 0) m_cs++;
      if (e_flush) m_cf++;
      if (m_pend) m_ch++;
      if (m_pend && e_flush) m_pend = 0;
      else if (!m_pend && wrong && (!rdy_in || smem)) begin
        m_pend = 1; m_addr = tgt;
      end
    end
    #1;
  endtask

  task automatic idle();
    set_in(1, 1, 0, 0, 0, 0, 32'h0);
  endtask

  task automatic test_reset();
    set_in(0, 1'($urandom), 1, 1, 1, 1, $urandom);
    checks++;
    if (stall !== 6'b0 || flush_o !== 1'b0 || redirect_pc_o !== 32'h0 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: got stall=%b flush=%b pc=%h busy=%b, want all zero",
               stall, flush_o, redirect_pc_o, busy_o);
    end
    tick();
    idle();
    checks++;
    if (stall !== 6'b0 || flush_o !== 1'b0 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: got stall=%b flush=%b busy=%b, want 0", stall, flush_o, busy_o);
    end
    tick();
  endtask

  task automatic test_priority();
    logic [5:0] want [4];
    want[0] = 6'b000011; want[1] = 6'b000111; want[2] = 6'b011111; want[3] = 6'b111111;
    for (int k = 0; k < 4; k++) begin
      set_in(1, k != 3, 1, k >= 1, k >= 2, 0, 32'h0);
      checks++;
      if (stall !== want[k]) begin
        failures++;
        $display("FAIL priority_%0d: got %b want %b", k, stall, want[k]);
      end
      tick();
    end
  endtask

  task automatic test_immediate();
    set_in(1, 1, 0, 0, 0, 1, 32'h0000_1040);
    checks++;
    if (flush_o !== 1'b1 || redirect_pc_o !== 32'h1040 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL immediate: got flush=%b pc=%h busy=%b want 1/00001040/0", flush_o, redirect_pc_o, busy_o);
    end
    tick();
    idle();
    checks++;
    if (flush_o !== 1'b0 || redirect_pc_o !== 32'h0) begin
      failures++;
      $display("FAIL immediate_after: got flush=%b pc=%h want 0/0", flush_o, redirect_pc_o);
    end
    tick();
  endtask

  task automatic test_deferred();
    set_in(1, 1, 0, 0, 1, 0, 32'h0);
    tick();
    set_in(1, 1, 0, 0, 1, 1, 32'h2000);
    checks++;
    if (flush_o !== 1'b0 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL deferred_latch: got flush=%b busy=%b want 0/0", flush_o, busy_o);
    end
    tick();
    for (int k = 0; k < 3; k++) begin
      set_in(1, 1, 0, 0, 1, 1, 32'h3000);
      checks++;
      if (flush_o !== 1'b0 || busy_o !== 1'b1 || redirect_pc_o !== 32'h0) begin
        failures++;
        $display("FAIL deferred_hold_%0d: got flush=%b busy=%b pc=%h want 0/1/0", k, flush_o, busy_o, redirect_pc_o);
      end
      tick();
    end
    set_in(1, 1, 0, 0, 0, 0, 32'h3000);
    checks++;
    if (flush_o !== 1'b1 || redirect_pc_o !== 32'h2000) begin
      failures++;
      $display("FAIL deferred_release: got flush=%b pc=%h want 1/00002000", flush_o, redirect_pc_o);
    end
    tick();
    idle();
    checks++;
    if (flush_o !== 1'b0 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL deferred_done: got flush=%b busy=%b want 0/0", flush_o, busy_o);
    end
    tick();
  endtask

  task automatic test_hazard_suppress();
    set_in(1, 1, 0, 1, 0, 1, 32'h0000_0044);
    checks++;
    if (stall !== 6'b0 || flush_o !== 1'b1) begin
      failures++;
      $display("FAIL hazard_suppress: got stall=%b flush=%b want 000000/1", stall, flush_o);
    end
    tick();
  endtask

  task automatic test_reset_hold();
    set_in(1, 1, 0, 0, 1, 1, 32'h2000);
    tick();
    set_in(0, 1, 0, 0, 1, 0, 32'h0);
    checks++;
    if (busy_o !== 1'b0 || stall !== 6'b0) begin
      failures++;
      $display("FAIL reset_hold_during: got busy=%b stall=%b want 0/0", busy_o, stall);
    end
    tick();
    for (int k = 0; k < 3; k++) begin
      idle();
      checks++;
      if (busy_o !== 1'b0 || flush_o !== 1'b0 || redirect_pc_o !== 32'h0) begin
        failures++;
        $display("FAIL reset_hold_after_%0d: got busy=%b flush=%b pc=%h want 0/0/0", k, busy_o, flush_o, redirect_pc_o);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) begin
      logic [31:0] t;
      t = 32'h0000_5000 + 32'(k) * 32'h10;
      set_in(1, 1, 0, 0, 0, 1, t);
      checks++;
      if (flush_o !== 1'b1 || redirect_pc_o !== t || busy_o !== 1'b0) begin
        failures++;
        $display("FAIL back_to_back_%0d: got flush=%b pc=%h busy=%b want 1/%h/0", k, flush_o, redirect_pc_o, busy_o, t);
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      set_in($urandom_range(19) != 0, $urandom_range(7) != 0, $urandom_range(2) == 0,
             $urandom_range(2) == 0, $urandom_range(3) == 0, $urandom_range(2) == 0, $urandom);
      checks++;
      if (stall !== e_stall || flush_o !== e_flush || redirect_pc_o !== e_pc || busy_o !== e_busy) begin
        failures++;
        $display("FAIL random_%0d: got stall=%b flush=%b pc=%h busy=%b want %b/%b/%h/%b",
                 n, stall, flush_o, redirect_pc_o, busy_o, e_stall, e_flush, e_pc, e_busy);
      end
      tick();
`ifdef PIPE_PERF_CNT_EN
      checks++;
      if (cs !== 32'(m_cs) || cf !== 32'(m_cf) || ch !== 32'(m_ch) ||
          cs2 !== 2'(m_cs > 3 ? 3 : m_cs) || cf2 !== 2'(m_cf > 3 ? 3 : m_cf) || ch2 !== 2'(m_ch > 3 ? 3 : m_ch)) begin
        failures++;
        $display("FAIL random_cnt_%0d: got %0d/%0d/%0d sat %0d/%0d/%0d want %0d/%0d/%0d",
                 n, cs, cf, ch, cs2, cf2, ch2, m_cs, m_cf, m_ch);
      end
`endif
    end
  endtask

`ifdef PIPE_PERF_CNT_EN
  task automatic test_counters();
    set_in(0, 1, 0, 0, 0, 0, 32'h0); tick();
    set_in(1, 1, 0, 0, 0, 1, 32'h100); tick();   // flush 1
    set_in(1, 1, 0, 0, 1, 1, 32'h200); tick();   // stall 1, enter HOLD
    set_in(1, 1, 0, 0, 1, 0, 32'h0); tick();     // stall 2, hold 1
    set_in(1, 1, 0, 0, 1, 0, 32'h0); tick();     // stall 3, hold 2
    set_in(1, 1, 0, 0, 0, 0, 32'h0); tick();     // flush 2, hold 3
    set_in(1, 1, 1, 0, 0, 0, 32'h0); tick();     // stall 4
    checks++;
    if (cs !== 32'd4 || cf !== 32'd2 || ch !== 32'd3) begin
      failures++;
      $display("FAIL counters: got %0d/%0d/%0d want 4/2/3", cs, cf, ch);
    end
    set_in(1, 1, 1, 0, 0, 0, 32'h0); tick();     // stall 5
    checks++;
    if (cs !== 32'd5 || cs2 !== 2'd3 || cf2 !== 2'd2 || ch2 !== 2'd3) begin
      failures++;
      $display("FAIL counters_sat: got %0d sat %0d/%0d/%0d want 5 sat 3/2/3", cs, cs2, cf2, ch2);
    end
  endtask
`endif

  initial begin
    rst = 0; rdy_in = 1; sif = 0; sid = 0; smem = 0; wrong = 0; tgt = 0;
    m_pend = 0; m_addr = 0; m_cs = 0; m_cf = 0; m_ch = 0;
    @(posedge clk); #1;
    test_reset();
    test_priority();
    test_immediate();
    test_deferred();
    test_hazard_suppress();
    test_reset_hold();
    test_back_to_back();
`ifdef PIPE_PERF_CNT_EN
    test_counters();
`endif
    test_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
